// File: rtl/gacc_pkg.sv
// Shared definitions for the group-accumulator beat accumulator.
// Holds the FSM state encoding and the default geometry constants.
package gacc_pkg;

  localparam int unsigned LANES_DEF  = 4;
  localparam int unsigned ACC_W_DEF  = 16;
  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned IN_W       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/gacc_beat_accumulator_lane_acc.sv
// One clearable, enable-gated unsigned lane accumulator (modulo 2^ACC_W).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, clears the sum
//   clr  - synchronous clear at job start
//   en   - add din to the running sum this cycle
//   din  - unsigned byte to accumulate
//   sum  - registered running sum
module lane_acc
  import gacc_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [BYTE_W-1:0] din,
  output logic [ACC_W-1:0]  sum
);

  // Byte is zero-extended; overflow wraps naturally at ACC_W bits.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + ACC_W'(din);
    end
  end

endmodule

// File: rtl/gacc_beat_accumulator.sv
// Accumulates N packed group-accumulator words into per-lane byte sums.
// A job starts with a start pulse in IDLE carrying beat_count = N; each
// accepted in_data word adds byte i into lane i. After the N-th beat the
// sums are presented on out_data with out_valid until out_ready.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   start, beat_count  - job request and length, sampled only in IDLE
//   in_valid/in_ready  - input word handshake, in_data byte i -> lane i
//   out_valid/out_ready- result handshake, out_data lane i at ACC_W*i
//   busy               - high whenever the FSM is not IDLE
module gacc_beat_accumulator
  import gacc_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       beat_count,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] out_data,
  output logic                   busy
);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] remaining_q;
  logic             clear_c;
  logic             xfer_c;
  logic             last_c;
  logic             in_ready_d;
  logic             out_valid_d;
  logic             busy_d;

  assign clear_c = (state_q == IDLE) && start;
  assign xfer_c  = in_valid && in_ready;
  assign last_c  = (remaining_q == CNT_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (beat_count != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (xfer_c && last_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so the flops track the state register.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    case (state_d)
      ACCUM: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      DONE: begin
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

  // Remaining-beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
    end else if (clear_c) begin
      remaining_q <= beat_count;
    end else if (xfer_c) begin
      remaining_q <= remaining_q - CNT_W'(1);
    end
  end

  // Per-lane accumulators; sums persist after DONE until the next start.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_acc #(
      .ACC_W (ACC_W)
    ) u_lane_acc (
      .clk (clk),
      .rst (rst),
      .clr (clear_c),
      .en  (xfer_c),
      .din (in_data[BYTE_W*i +: BYTE_W]),
      .sum (out_data[ACC_W*i +: ACC_W])
    );
  end

endmodule

// File: tb/tb_gacc_beat_accumulator.sv
module tb_gacc_beat_accumulator;

  localparam int unsigned LANES = 4;
  localparam int unsigned ACC_W = 16;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DW    = LANES * ACC_W;
  localparam int          MAX_CYC = 5000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] beat_count;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // Reference model: per-lane sums of every accepted byte, mod 2^ACC_W.
  int unsigned sums[LANES];
  int          xfers;

  always #5 clk = ~clk;

  gacc_beat_accumulator #(
    .LANES (LANES),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .beat_count (beat_count),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_vec();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[i*ACC_W +: ACC_W] = ACC_W'(sums[i]);
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LANES; i++) sums[i] = 0;
    xfers = 0;
  endtask

  task automatic model_add(input logic [31:0] d);
    for (int i = 0; i < LANES; i++) sums[i] = (sums[i] + int'(d[i*8 +: 8])) % (1 << ACC_W);
    xfers++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},   DW'(busy),      '0);
    check({tag, "_ready"},  DW'(in_ready),  '0);
    check({tag, "_ovalid"}, DW'(out_valid), '0);
  endtask

  // One complete job: start, n beats at vpct% valid density, hold cycles of
  // backpressure in DONE (with start and in_valid asserted), then handshake.
  task automatic run_job(input int n, input int vpct, input bit fixed,
                         input logic [31:0] fval, input int hold);
    int cyc;
    check_idle("pre_job");
    start      = 1'b1;
    beat_count = CNT_W'(n);
    in_valid   = 1'b1;
    in_data    = $urandom;
    tick();
    model_clear();
    start = 1'b0;
    cyc   = 0;
    while (xfers < n && cyc < MAX_CYC) begin
      check("accum_ready",  DW'(in_ready),  DW'(1));
      check("accum_ovalid", DW'(out_valid), '0);
      check("accum_busy",   DW'(busy),      DW'(1));
      in_valid   = ($urandom_range(99) < 32'(vpct));
      in_data    = fixed ? fval : $urandom;
      start      = 1'($urandom_range(1));
      beat_count = CNT_W'($urandom);
      tick();
      if (in_valid) model_add(in_data);
      cyc++;
    end
    if (cyc >= MAX_CYC) check("accum_timeout", DW'(1), '0);
    check("done_ovalid", DW'(out_valid), DW'(1));
    check("done_ready",  DW'(in_ready),  '0);
    check("done_data",   out_data,       model_vec());
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = 1'b1;
      in_valid  = 1'b1;
      in_data   = $urandom;
      tick();
      check("hold_ovalid", DW'(out_valid), DW'(1));
      check("hold_ready",  DW'(in_ready),  '0);
      check("hold_data",   out_data,       model_vec());
    end
    out_ready = 1'b1;
    start     = 1'b1;
    in_valid  = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    check_idle("post_hs");
    check("post_hs_data", out_data, model_vec());
    tick();
    check_idle("post_hs2");
    check("post_hs2_data", out_data, model_vec());
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    beat_count = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    model_clear();
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");
    check("reset_data", out_data, '0);

    // Back-to-back fixed beats with known lane totals.
    run_job(3, 100, 1'b1, 32'h0102_0304, 0);
    check("n3_lanes", out_data, 64'h0003_0006_0009_000C);

    // Largest job of saturated bytes: 255 * 0xFF must not wrap.
    run_job(255, 50, 1'b1, 32'hFFFF_FFFF, 0);
    check("n255_lanes", out_data, 64'hFE01_FE01_FE01_FE01);

    // Zero-length job goes straight to DONE with cleared sums.
    run_job(0, 100, 1'b0, '0, 0);
    check("n0_lanes", out_data, '0);

    // Backpressure in DONE with start pulsed.
    run_job(2, 100, 1'b0, '0, 5);

    // Reset in the middle of a four-beat job.
    start      = 1'b1;
    beat_count = CNT_W'(4);
    tick();
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      in_data  = $urandom | 32'h0101_0101;
      tick();
    end
    rst      = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    tick();
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    check_idle("midrst");
    check("midrst_data", out_data, '0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("midrst_no_ovalid", DW'(out_valid), '0);
    end
    run_job(1, 100, 1'b1, 32'h0000_0080, 0);
    check("after_rst_lanes", out_data, 64'h0000_0000_0000_0080);

    // Random jobs.
    for (int j = 0; j < 8; j++) begin
      run_job(int'($urandom_range(20, 1)), int'($urandom_range(100, 30)), 1'b0, '0,
              int'($urandom_range(3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gacc_beat_accumulator.md
GACC_BEAT_ACCUMULATOR -- requirements
Module: gacc_beat_accumulator

Interface
REQ-001 The module SHALL expose parameter LANES, default 4, the number of byte lanes in the 32-bit group-accumulator result word.
REQ-002 The module SHALL expose parameter ACC_W, default 16, the width of each per-lane running sum.
REQ-003 The module SHALL expose parameter CNT_W, default 8, the width of the beat-count field.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 Port: clk  input  1  rising-edge clock for all state.
REQ-006 Port: rst  input  1  synchronous active-high reset.
REQ-007 Port: start  input  1  single-cycle pulse that begins a job; sampled only in IDLE.
REQ-008 Port: beat_count  input  CNT_W  number of result words N in the job; sampled with start.
REQ-009 Port: in_valid  input  1  upstream gacc word valid.
REQ-010 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-011 Port: in_data  input  32  packed group-accumulator word; byte i (bits 8i+7:8i) belongs to lane i.
REQ-012 Port: out_valid  output  1  lane sums valid.
REQ-013 Port: out_ready  input  1  downstream accepts out_data.
REQ-014 Port: out_data  output  LANES*ACC_W  lane i sum at bits ACC_W*i+ACC_W-1:ACC_W*i.
REQ-015 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM, DONE.
REQ-017 In IDLE with start=1 and beat_count!=0, the block SHALL clear all lane sums, load the remaining counter with beat_count, and enter ACCUM.
REQ-018 In IDLE with start=1 and beat_count=0, the block SHALL clear all lane sums and enter DONE directly (zero-length job).
REQ-019 start SHALL be ignored in ACCUM and DONE.
REQ-020 in_ready SHALL be 1 only in ACCUM; in_ready SHALL NOT depend combinationally on in_valid.
REQ-021 A beat SHALL transfer on a cycle with in_valid=1 and in_ready=1; lane i sum SHALL add the zero-extended unsigned byte i of in_data.
REQ-022 Each transfer SHALL decrement the remaining counter by 1; the transfer with remaining=1 SHALL move the FSM to DONE.
REQ-023 Cycles with in_valid=0 in ACCUM SHALL leave sums and counter unchanged.
REQ-024 out_valid SHALL be 1 exactly in DONE, first asserting the cycle after the last beat transfers (latency 1).
REQ-025 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 In DONE with out_ready=1 the FSM SHALL return to IDLE next cycle; out_data SHALL retain the last sums until the next start.
REQ-027 Lane arithmetic SHALL be unsigned, modulo 2^ACC_W; with defaults, 255 beats of 0xFF (65025) SHALL not wrap.
REQ-028 A start in the same cycle as the DONE->IDLE handshake SHALL be ignored (start is sampled only in IDLE).

Reset
REQ-029 On rst=1 the FSM SHALL go to IDLE, counter to 0, all lane sums to 0.
REQ-030 Outputs after reset SHALL be in_ready=0, out_valid=0, busy=0, out_data=0.
REQ-031 rst asserted mid-job (ACCUM or DONE) SHALL abandon the job without emitting out_valid; rst SHALL take priority over start and any handshake in the same cycle.

Structure
REQ-032 A shared package gacc_pkg SHALL hold the state enum (IDLE, ACCUM, DONE) and default LANES/ACC_W/CNT_W constants.
REQ-033 A sub-module lane_acc SHALL implement one ACC_W-bit clearable, enable-gated lane accumulator, instantiated LANES times.
REQ-034 All state SHALL be on clk; no latches, no other clocks.

Verification
REQ-035 Scenario: start with N=3, beats 0x01020304, 0x01020304, 0x01020304 back-to-back, out_ready=1 -> out_data lanes {3:3, 2:6, 1:9, 0:12}, out_valid for 1 cycle, 1 cycle after third beat.
REQ-036 Scenario: N=255, every beat 0xFFFFFFFF, in_valid toggling 50% -> all lanes 0xFE01, exactly 255 transfers, no wrap.
REQ-037 Scenario: start with N=0 -> out_valid next cycle, out_data=0, in_ready never asserts.
REQ-038 Scenario: N=2 job complete, out_ready held 0 for 5 cycles, start pulsed during DONE -> out_valid and out_data stable for 5 cycles, start ignored, IDLE after handshake.
REQ-039 Scenario: N=4, rst pulsed after 2nd beat -> all outputs 0, busy=0, no out_valid; subsequent N=1 job with 0x00000080 yields lane0=0x0080, others 0.
REQ-040 Scenario: in_valid=1 in IDLE and DONE -> no transfer occurs, sums unchanged.
